// File: rtl/tree_acc_pkg.sv
// Shared types and constants for the tree-sum accumulator slice.
package tree_acc_pkg;

    typedef enum logic {IDLE, ACCUM} tree_acc_state_e;

    localparam int HALF_WIDTH = 16;

endpackage

// File: rtl/result_skid_reg.sv
// Single-entry valid/ready output buffer: a load always wins over a drain,
// so a result can be replaced in the same cycle the old one is consumed.
module result_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates a programmed number of tree-adder beats into one result and
// hands it to the consumer through a single-entry output buffer.
module tree_sum_accumulator
    import tree_acc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_LEN    = 256,
    localparam int CNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CNT_WIDTH-1:0]  acc_len_i,
    input  logic                  halved_precision_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    tree_acc_state_e state, next_state;

    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  len_q;
    logic                  hp_q;

    logic [CNT_WIDTH-1:0]  eff_len;
    logic                  last_pending;
    logic                  accept;
    logic                  finish;
    logic                  hp_sel;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] result;

    always_comb begin
        if (acc_len_i == '0) begin
            eff_len = CNT_WIDTH'(1);
        end else if (acc_len_i > CNT_WIDTH'(MAX_LEN)) begin
            eff_len = CNT_WIDTH'(MAX_LEN);
        end else begin
            eff_len = acc_len_i;
        end
    end

    // In IDLE the run length is not latched yet, so look at the live config.
    assign last_pending = (state == IDLE) ? (eff_len == CNT_WIDTH'(1))
                                          : (cnt + CNT_WIDTH'(1) == len_q);
    assign in_ready_o   = !clear_i && !(last_pending && out_valid_o && !out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign finish       = accept && last_pending;

    // acc is always zero in IDLE, so the same adder serves the first beat.
    assign sum    = acc + in_data_i;
    assign hp_sel = (state == IDLE) ? halved_precision_i : hp_q;
    assign result = hp_sel ? {{(DATA_WIDTH - HALF_WIDTH){sum[HALF_WIDTH-1]}}, sum[HALF_WIDTH-1:0]}
                           : sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept && !last_pending) next_state = ACCUM;
                ACCUM:   if (finish)                  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            hp_q  <= 1'b0;
        end else if (clear_i || finish) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_WIDTH'(1);
            if (state == IDLE) begin
                len_q <= eff_len;
                hp_q  <= halved_precision_i;
            end
        end
    end

    result_skid_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_result (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (finish),
        .load_data (result),
        .drain     (out_ready_i),
        .data      (out_data_o),
        .valid     (out_valid_o)
    );

    assign busy_o = (state == ACCUM);

endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
- Downstream stage of the configurable binary tree adder. Consumes its 32-bit sign-extended reduction result one beat per cycle.
- Accumulates a run-time-programmed number of beats, e.g. the K-dimension tiles of a dot product, into one result.
- Presents the result on a registered valid/ready output with a single-entry output buffer, so the next run overlaps with the result waiting for the consumer.

Parameters:
- DATA_WIDTH, 32, width of input beats, accumulator and result.
- MAX_LEN, 256, maximum beats per run.
- CNT_WIDTH, $clog2(MAX_LEN+1), derived localparam; width of length and counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_data_i  in  DATA_WIDTH  tree-adder sum, two's complement.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid and ready are both high.
- acc_len_i  in  CNT_WIDTH  beats per run; sampled on the first beat of a run.
- halved_precision_i  in  1  16-bit wrap mode; sampled on the first beat of a run.
- clear_i  in  1  synchronous abort of the current run.
- out_data_o  out  DATA_WIDTH  accumulated result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- busy_o  out  1  a run is in progress (state ACCUM).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni). Reset forces state IDLE, acc=0, cnt=0, len_q=0, hp_q=0, out_data_o=0, out_valid_o=0, busy_o=0.
- FSM IDLE:
  - An accepted beat starts a run.
  - Latches len_q = (acc_len_i==0 ? 1 : min(acc_len_i, MAX_LEN)) and hp_q = halved_precision_i.
  - Sets acc = in_data_i, cnt = 1.
  - If len_q==1 the run finishes immediately (see finish). Otherwise go to ACCUM.
- FSM ACCUM:
  - Each accepted beat does acc += in_data_i and cnt += 1.
  - The beat with cnt+1 == len_q is the last beat: finish and return to IDLE.
- Finish, on last-beat accept:
  - out_data_o <= hp_q ? sign-extend(sum[15:0]) : sum, where sum = acc + in_data_i.
  - out_valid_o <= 1; acc and cnt cleared.
  - Latency: result is visible the cycle after the last beat is accepted.
- Arithmetic: DATA_WIDTH two's complement with wrap-around and no saturation. In halved mode the result wraps at 16 bits.
- Output buffer:
  - out_valid_o clears on out_ready_i unless a new finish occurs in the same cycle. A simultaneous finish and drain loads the new result and keeps out_valid_o=1.
  - out_data_o is held stable while out_valid_o=1 and out_ready_i=0.
- in_ready_o = !clear_i && !(last_pending && out_valid_o && !out_ready_i).
  - last_pending means the next accepted beat completes the run.
  - Non-last beats are never stalled by a full output.
  - in_ready_o does not depend on in_valid_i.
- clear_i:
  - Returns the FSM to IDLE and zeroes acc and cnt.
  - Forces in_ready_o=0, so a simultaneous beat is dropped.
  - Does not affect a pending out_valid_o or out_data_o.
- Config changes on acc_len_i or halved_precision_i mid-run have no effect until the next run.
- busy_o = (state == ACCUM).
- Reset asserted mid-run or with a pending output: all state is discarded immediately.

Decomposition:
- Shared package tree_acc_pkg holds:
  - typedef enum logic {IDLE, ACCUM} tree_acc_state_e;
  - localparam HALF_WIDTH = 16.
- One natural sub-module: result_skid_reg, the single-entry valid/ready output buffer with load and drain.
- Counter and accumulator stay inline.

Test Plan:
- Length 4, halved=0, beats 10,-3,7,100 back-to-back, out_ready=1 -> out_data=114, out_valid for exactly 1 cycle, 1 cycle after the 4th accept.
- Length 2, halved=1, beats 0x7FFF and 0x0002 -> out_data=0xFFFF8001 (16-bit wrap, sign-extended). Same beats with halved=0 -> 0x00008001.
- Length 2, out_ready held 0: first run 1,2 -> result 3 held. Second run: beat 5 accepted, then in_ready=0 on the last-pending beat. Raise out_ready -> 3 drained in that cycle, beat 6 accepted, next result 11.
- acc_len=0 with beat 42 -> treated as 1; result 42 one cycle later, busy_o never asserted. acc_len=1 behaves identically.
- Length 3, beats 0x7FFFFFFF,1,0 -> out_data=0x80000000 (32-bit wrap).
- Length 4, two beats (1,1), then clear_i together with a valid beat 9 -> in_ready=0, beat dropped, busy_o=0. New run 2,2,2,2 -> 8. Also assert rst_ni low mid-run with a pending output -> all outputs 0 asynchronously.
